// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with one shared ALU and memory port; retire 3-5 cycles per instruction.
// Memory backpressure: MemReq holds until mem_ready, and a stalled request traps after TIMEOUT_CYCLES wait cycles.
module multicycle_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter bit          STRICT_DECODE  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic        BranchTaken,
  input  logic        mem_ready,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        AdrSrc,
  output logic        MemReq,
  output logic [1:0]  MemWrite,
  output logic [1:0]  ResultSrc,
  output logic        LoadUnsigned,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [3:0]  ALUControl,
  output logic [2:0]  ImmSrc,
  output logic [1:0]  PCSrc,
  output logic        instr_retired,
  output logic        illegal_instr,
  output logic        mem_fault,
  output logic [3:0]  state_o
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_EXEC_R    = 4'd3,
    S_EXEC_I    = 4'd4,
    S_MEM_ADDR  = 4'd5,
    S_MEM_READ  = 4'd6,
    S_MEM_WRITE = 4'd7,
    S_MEM_WB    = 4'd8,
    S_ALU_WB    = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_UPPER     = 4'd12,
    S_TRAP      = 4'd13
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_AND  = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT_CYCLES - 1);

  state_t     state, next;
  logic [7:0] wait_cnt;
  logic       illegal, timeout, set_illegal, set_fault;
  logic       unused_fields;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode        = Instr[6:0];
  assign funct3        = Instr[14:12];
  assign funct7        = Instr[31:25];
  assign unused_fields = ^{Instr[24:15], Instr[11:7]};
  assign state_o       = state;

  // Last permitted wait cycle without mem_ready; a same-cycle ready still completes.
  assign timeout = MemReq && !mem_ready && (wait_cnt == WAIT_LIMIT);

  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic b30, input logic is_r);
    case (f3)
      3'b000:  alu_decode = (is_r && b30) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_decode = ALU_SLL;
      3'b010:  alu_decode = ALU_SLT;
      3'b011:  alu_decode = ALU_SLTU;
      3'b100:  alu_decode = ALU_XOR;
      3'b101:  alu_decode = b30 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_decode = ALU_OR;
      default: alu_decode = ALU_AND;
    endcase
  endfunction

  // Byte/half/word share one 2-bit size code for both load select and store strobe.
  function automatic logic [1:0] size_code(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   size_code = 2'b11;
      2'b01:   size_code = 2'b10;
      default: size_code = 2'b01;
    endcase
  endfunction

  always_comb begin
    illegal = 1'b0;
    case (opcode)
      OP_R:      illegal = !((funct7 == 7'b0000000) ||
                             ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      OP_I:      illegal = (funct3 == 3'b001) && (funct7 != 7'b0000000);
      OP_LOAD:   illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      OP_STORE:  illegal = (funct3 > 3'b010);
      OP_BRANCH: illegal = (funct3[2:1] == 2'b01);
      OP_JALR:   illegal = (funct3 != 3'b000);
      OP_JAL, OP_LUI, OP_AUIPC: illegal = 1'b0;
      default:   illegal = 1'b1;
    endcase
  end

  always_comb begin
    next          = state;
    IRWrite       = 1'b0;
    PCWrite       = 1'b0;
    RegWrite      = 1'b0;
    AdrSrc        = 1'b0;
    MemReq        = 1'b0;
    MemWrite      = 2'b00;
    ResultSrc     = 2'b00;
    LoadUnsigned  = 1'b0;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    ALUControl    = ALU_ADD;
    ImmSrc        = (state == S_IDLE) ? 3'b000 : 3'b111;
    PCSrc         = 2'b00;
    instr_retired = 1'b0;
    set_illegal   = 1'b0;
    set_fault     = 1'b0;

    case (state)
      S_IDLE: next = S_FETCH;

      S_FETCH: begin
        MemReq  = 1'b1;
        IRWrite = mem_ready;
        if (mem_ready)    next = S_DECODE;
        else if (timeout) begin next = S_TRAP; set_fault = 1'b1; end
      end

      S_DECODE: begin
        if (illegal) begin
          if (STRICT_DECODE) begin
            next        = S_TRAP;
            set_illegal = 1'b1;
          end else begin
            PCWrite       = 1'b1;
            instr_retired = 1'b1;
            next          = S_FETCH;
          end
        end else begin
          case (opcode)
            OP_R:               next = S_EXEC_R;
            OP_I:               next = S_EXEC_I;
            OP_LOAD, OP_STORE:  next = S_MEM_ADDR;
            OP_BRANCH:          next = S_BRANCH;
            OP_JAL, OP_JALR:    next = S_JUMP;
            default:            next = S_UPPER;
          endcase
        end
      end

      S_EXEC_R: begin
        ALUControl = alu_decode(funct3, Instr[30], 1'b1);
        next       = S_ALU_WB;
      end

      S_EXEC_I: begin
        ALUSrcB    = 2'b01;
        ImmSrc     = 3'b000;
        ALUControl = alu_decode(funct3, Instr[30], 1'b0);
        next       = S_ALU_WB;
      end

      S_ALU_WB: begin
        RegWrite      = 1'b1;
        PCWrite       = 1'b1;
        instr_retired = 1'b1;
        next          = S_FETCH;
      end

      S_MEM_ADDR: begin
        ALUSrcB = 2'b01;
        ImmSrc  = (opcode == OP_STORE) ? 3'b001 : 3'b000;
        next    = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
      end

      // Keep the address operands selected so the address is stable while stalled.
      S_MEM_READ: begin
        MemReq  = 1'b1;
        AdrSrc  = 1'b1;
        ALUSrcB = 2'b01;
        ImmSrc  = 3'b000;
        if (mem_ready)    next = S_MEM_WB;
        else if (timeout) begin next = S_TRAP; set_fault = 1'b1; end
      end

      S_MEM_WB: begin
        RegWrite      = 1'b1;
        ResultSrc     = size_code(funct3);
        LoadUnsigned  = funct3[2];
        PCWrite       = 1'b1;
        instr_retired = 1'b1;
        next          = S_FETCH;
      end

      S_MEM_WRITE: begin
        MemReq   = 1'b1;
        AdrSrc   = 1'b1;
        ALUSrcB  = 2'b01;
        ImmSrc   = 3'b001;
        MemWrite = size_code(funct3);
        if (mem_ready) begin
          PCWrite       = 1'b1;
          instr_retired = 1'b1;
          next          = S_FETCH;
        end else if (timeout) begin
          next      = S_TRAP;
          set_fault = 1'b1;
        end
      end

      S_BRANCH: begin
        ALUControl    = ALU_SUB;
        ImmSrc        = 3'b010;
        PCWrite       = 1'b1;
        PCSrc         = BranchTaken ? 2'b01 : 2'b00;
        instr_retired = 1'b1;
        next          = S_FETCH;
      end

      S_JUMP: begin
        ALUSrcA       = 2'b01;
        ALUSrcB       = 2'b10;
        RegWrite      = 1'b1;
        PCWrite       = 1'b1;
        ImmSrc        = (opcode == OP_JALR) ? 3'b000 : 3'b100;
        PCSrc         = (opcode == OP_JALR) ? 2'b10 : 2'b01;
        instr_retired = 1'b1;
        next          = S_FETCH;
      end

      S_UPPER: begin
        ALUSrcA       = (opcode == OP_LUI) ? 2'b10 : 2'b01;
        ALUSrcB       = 2'b01;
        ImmSrc        = 3'b011;
        RegWrite      = 1'b1;
        PCWrite       = 1'b1;
        instr_retired = 1'b1;
        next          = S_FETCH;
      end

      S_TRAP: next = S_TRAP;

      default: next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      wait_cnt      <= '0;
      illegal_instr <= 1'b0;
      mem_fault     <= 1'b0;
    end else begin
      state <= next;
      if (next != state)
        wait_cnt <= '0;
      else if (MemReq && !mem_ready)
        wait_cnt <= wait_cnt + 8'd1;
      if (set_illegal) illegal_instr <= 1'b1;
      if (set_fault)   mem_fault     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed scenarios plus a random instruction stream checked against a latency/control model.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr;
  logic        BranchTaken;
  logic        mem_ready;

  logic ir_w, pc_w, rg_w, adr_src, mem_req, ld_u, retired, ill, mfault;
  logic [1:0] mem_wr, res_src, src_a, src_b, pc_src;
  logic [3:0] alu_ctl, state;
  logic [2:0] imm_src;

  logic n_ir_w, n_pc_w, n_rg_w, n_adr_src, n_mem_req, n_ld_u, n_retired, n_ill, n_mfault;
  logic [1:0] n_mem_wr, n_res_src, n_src_a, n_src_b, n_pc_src;
  logic [3:0] n_alu_ctl, n_state;
  logic [2:0] n_imm_src;

  logic [31:0] all_out, n_all_out;
  assign all_out = {2'b00, ir_w, pc_w, rg_w, adr_src, mem_req, mem_wr, res_src, ld_u, src_a, src_b,
                    alu_ctl, imm_src, pc_src, retired, ill, mfault, state};
  assign n_all_out = {2'b00, n_ir_w, n_pc_w, n_rg_w, n_adr_src, n_mem_req, n_mem_wr, n_res_src, n_ld_u,
                      n_src_a, n_src_b, n_alu_ctl, n_imm_src, n_pc_src, n_retired, n_ill, n_mfault, n_state};

  always #5 clk = ~clk;

  multicycle_controller #(.TIMEOUT_CYCLES(16), .STRICT_DECODE(1'b1)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .BranchTaken(BranchTaken), .mem_ready(mem_ready),
    .IRWrite(ir_w), .PCWrite(pc_w), .RegWrite(rg_w), .AdrSrc(adr_src), .MemReq(mem_req),
    .MemWrite(mem_wr), .ResultSrc(res_src), .LoadUnsigned(ld_u), .ALUSrcA(src_a), .ALUSrcB(src_b),
    .ALUControl(alu_ctl), .ImmSrc(imm_src), .PCSrc(pc_src), .instr_retired(retired),
    .illegal_instr(ill), .mem_fault(mfault), .state_o(state));

  multicycle_controller #(.TIMEOUT_CYCLES(16), .STRICT_DECODE(1'b0)) dut_ns (
    .clk(clk), .reset(reset), .Instr(Instr), .BranchTaken(BranchTaken), .mem_ready(mem_ready),
    .IRWrite(n_ir_w), .PCWrite(n_pc_w), .RegWrite(n_rg_w), .AdrSrc(n_adr_src), .MemReq(n_mem_req),
    .MemWrite(n_mem_wr), .ResultSrc(n_res_src), .LoadUnsigned(n_ld_u), .ALUSrcA(n_src_a), .ALUSrcB(n_src_b),
    .ALUControl(n_alu_ctl), .ImmSrc(n_imm_src), .PCSrc(n_pc_src), .instr_retired(n_retired),
    .illegal_instr(n_ill), .mem_fault(n_mfault), .state_o(n_state));

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [2:0] LD_F3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  localparam logic [2:0] BR_F3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
  localparam logic [3:0] ALU_BASE [8] = '{4'd0, 4'd7, 4'd2, 4'd3, 4'd4, 4'd8, 4'd5, 4'd6};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  // Drives one instruction from FETCH to retire; mem_ready answers each request after wf/wm wait cycles.
  task automatic run_instr(input logic [31:0] ins, input logic bt, input int wf, input int wm,
                           output int lat, output int regw, output logic [1:0] pcs, output logic pcw,
                           output logic [1:0] memw, output logic [1:0] rsrc, output logic lu,
                           output logic [3:0] alu_x, output logic [3:0] alu_r, output int drops);
    int nreq, wcnt;
    logic prev_hold;
    lat = -1; regw = 0; pcs = 2'b00; pcw = 1'b0; memw = 2'b00; rsrc = 2'b00; lu = 1'b0;
    alu_x = 4'h0; alu_r = 4'h0; drops = 0; nreq = 0; wcnt = 0; prev_hold = 1'b0;
    Instr = ins;
    BranchTaken = bt;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      if (mem_req) begin
        mem_ready = (wcnt >= ((nreq == 0) ? wf : wm));
        if (mem_ready) begin nreq++; wcnt = 0; end
        else wcnt++;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      if (prev_hold && !mem_req) drops++;
      prev_hold = mem_req && !mem_ready;
      if (rg_w) regw++;
      if (mem_req && mem_wr != 2'b00) memw = mem_wr;
      if (c == 3 + wf) alu_x = alu_ctl;
      if (retired) begin
        lat = c; pcs = pc_src; pcw = pc_w; rsrc = res_src; lu = ld_u; alu_r = alu_ctl;
        break;
      end
    end
  endtask

  function automatic logic [31:0] gen_instr(input int kind);
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [6:0]  f7;
    rd  = 5'($urandom);
    rs1 = 5'($urandom);
    rs2 = 5'($urandom);
    imm = 12'($urandom);
    f3  = 3'($urandom);
    case (kind)
      0: begin
        f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
      end
      1: begin
        if (f3 == 3'd1) imm[11:5] = 7'h00;
        if (f3 == 3'd5) imm[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return {imm, rs1, f3, rd, 7'b0010011};
      end
      2: return {imm, rs1, LD_F3[$urandom_range(0, 4)], rd, 7'b0000011};
      3: return {imm[11:5], rs2, rs1, 3'($urandom_range(0, 2)), imm[4:0], 7'b0100011};
      4: return {imm[11:5], rs2, rs1, BR_F3[$urandom_range(0, 5)], imm[4:0], 7'b1100011};
      5: return {20'($urandom), rd, 7'b1101111};
      6: return {imm, rs1, 3'b000, rd, 7'b1100111};
      7: return {20'($urandom), rd, 7'b0110111};
      default: return {20'($urandom), rd, 7'b0010111};
    endcase
  endfunction

  function automatic int exp_lat(input logic [31:0] ins, input int wf, input int wm);
    case (ins[6:0])
      7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111: return 3 + wf;
      7'b0110011, 7'b0010011: return 4 + wf;
      7'b0100011: return 4 + wf + wm;
      7'b0000011: return 5 + wf + wm;
      default: return -1;
    endcase
  endfunction

  function automatic logic [1:0] exp_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 2'b11;
      2'b01:   return 2'b10;
      default: return 2'b01;
    endcase
  endfunction

  function automatic logic [3:0] exp_alu(input logic [31:0] ins);
    logic is_r;
    is_r = (ins[6:0] == 7'b0110011);
    if (ins[14:12] == 3'd0 && is_r && ins[30]) return 4'd1;
    if (ins[14:12] == 3'd5 && ins[30]) return 4'd9;
    return ALU_BASE[ins[14:12]];
  endfunction

  initial begin
    int lat, regw, drops, lat_t, wf, wm;
    logic [1:0] pcs, memw, rsrc;
    logic pcw, lu, bt;
    logic [3:0] ax, ar;
    logic [31:0] ins;
    logic [6:0] op;

    reset = 1'b1; Instr = 32'h0; BranchTaken = 1'b0; mem_ready = 1'b0;

    // Reset and first transitions.
    do_reset();
    check("idle_state", 32'(state), 32'd0);
    check("idle_outputs", all_out, 32'd0);
    check("idle_outputs_ns", n_all_out, 32'd0);
    @(negedge clk); #1;
    check("fetch_state", 32'(state), 32'd1);
    check("fetch_req", 32'(mem_req), 32'd1);

    // ADD x3,x1,x2 with zero-wait memory.
    do_reset();
    run_instr(32'h002081B3, 1'b0, 0, 0, lat, regw, pcs, pcw, memw, rsrc, lu, ax, ar, drops);
    check("add_lat", 32'(lat), 32'd4);
    check("add_alu", 32'(ax), 32'd0);
    check("add_regw", 32'(regw), 32'd1);
    check("add_pcsrc", 32'(pcs), 32'd0);

    // LBU with three wait cycles on the data read.
    run_instr(32'h0000C183, 1'b0, 0, 3, lat, regw, pcs, pcw, memw, rsrc, lu, ax, ar, drops);
    check("lbu_lat", 32'(lat), 32'd8);
    check("lbu_rsrc", 32'(rsrc), 32'd3);
    check("lbu_unsigned", 32'(lu), 32'd1);
    check("lbu_req_held", 32'(drops), 32'd0);

    // BEQ taken, then not taken.
    run_instr(32'h00208463, 1'b1, 0, 0, lat, regw, pcs, pcw, memw, rsrc, lu, ax, ar, drops);
    check("beq_t_lat", 32'(lat), 32'd3);
    check("beq_t_pcsrc", 32'(pcs), 32'd1);
    check("beq_t_pcw", 32'(pcw), 32'd1);
    check("beq_t_alu", 32'(ar), 32'd1);
    run_instr(32'h00208463, 1'b0, 0, 0, lat, regw, pcs, pcw, memw, rsrc, lu, ax, ar, drops);
    check("beq_n_lat", 32'(lat), 32'd3);
    check("beq_n_pcsrc", 32'(pcs), 32'd0);
    check("beq_n_pcw", 32'(pcw), 32'd1);

    // Fetch timeout: 16 wait cycles then TRAP with mem_fault.
    do_reset();
    Instr = 32'h002081B3;
    lat_t = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      if (c == 16) check("timeout_req_held", 32'(mem_req), 32'd1);
      if (state == 4'd13) begin lat_t = c; break; end
    end
    check("timeout_entry", 32'(lat_t), 32'd17);
    check("timeout_fault", 32'(mfault), 32'd1);
    repeat (4) @(negedge clk);
    #1;
    check("trap_hold", 32'(state), 32'd13);
    check("trap_no_req", 32'(mem_req), 32'd0);
    check("trap_fault_sticky", 32'(mfault), 32'd1);

    // mem_ready on the 16th cycle wins over the timeout.
    do_reset();
    check("fault_cleared", 32'(mfault), 32'd0);
    run_instr(32'h002081B3, 1'b0, 15, 0, lat, regw, pcs, pcw, memw, rsrc, lu, ax, ar, drops);
    check("late_ready_lat", 32'(lat), 32'd19);
    check("late_ready_nofault", 32'(mfault), 32'd0);

    // Illegal opcode 0x7F under both decode policies.
    do_reset();
    Instr = 32'h0000007F;
    @(negedge clk); mem_ready = 1'b1; #1;
    check("ill_fetch", 32'(state), 32'd1);
    @(negedge clk); #1;
    check("ill_ns_retire", 32'(n_retired), 32'd1);
    check("ill_ns_pcw", 32'(n_pc_w), 32'd1);
    check("ill_ns_pcsrc", 32'(n_pc_src), 32'd0);
    check("ill_ns_regw", 32'(n_rg_w), 32'd0);
    check("ill_strict_noretire", 32'(retired), 32'd0);
    @(negedge clk); #1;
    check("ill_trap", 32'(state), 32'd13);
    check("ill_flag", 32'(ill), 32'd1);
    check("ill_ns_fetch", 32'(n_state), 32'd1);
    check("ill_ns_noflag", 32'(n_ill), 32'd0);
    repeat (4) @(negedge clk);
    #1;
    check("ill_trap_hold", 32'(state), 32'd13);
    check("ill_trap_noreq", 32'(mem_req), 32'd0);
    do_reset();
    check("ill_cleared", 32'(ill), 32'd0);

    // Random legal instruction stream against the model.
    for (int i = 0; i < 40; i++) begin
      ins = gen_instr($urandom_range(0, 8));
      wf  = $urandom_range(0, 3);
      wm  = $urandom_range(0, 3);
      bt  = 1'($urandom_range(0, 1));
      op  = ins[6:0];
      run_instr(ins, bt, wf, wm, lat, regw, pcs, pcw, memw, rsrc, lu, ax, ar, drops);
      check("rnd_lat", 32'(lat), 32'(exp_lat(ins, wf, wm)));
      check("rnd_regw", 32'(regw), (op == 7'b0100011 || op == 7'b1100011) ? 32'd0 : 32'd1);
      check("rnd_pcw", 32'(pcw), 32'd1);
      check("rnd_pcsrc", 32'(pcs),
            (op == 7'b1100011) ? 32'(bt) : (op == 7'b1101111) ? 32'd1 : (op == 7'b1100111) ? 32'd2 : 32'd0);
      check("rnd_memw", 32'(memw), (op == 7'b0100011) ? 32'(exp_size(ins[14:12])) : 32'd0);
      check("rnd_rsrc", 32'(rsrc), (op == 7'b0000011) ? 32'(exp_size(ins[14:12])) : 32'd0);
      check("rnd_lu", 32'(lu), (op == 7'b0000011) ? 32'(ins[14]) : 32'd0);
      check("rnd_req_held", 32'(drops), 32'd0);
      if (op == 7'b0110011 || op == 7'b0010011) check("rnd_alu", 32'(ax), 32'(exp_alu(ins)));
      if (op == 7'b1100011) check("rnd_br_alu", 32'(ar), 32'd1);
    end
    check("rnd_no_fault", 32'(mfault), 32'd0);
    check("rnd_no_illegal", 32'(ill), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected below 400000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
